// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment byte writer: active-low segment codes, buffer depth, FSM states.
// No logic; pure declarations, imported by the decoder and the writer.
package seg_pkg;

  localparam int SEG_DEPTH = 8;

  // Active-low patterns, bit7=a ... bit1=g, bit0=dp.
  localparam logic [7:0] SEG_0 = 8'h03;
  localparam logic [7:0] SEG_1 = 8'h9F;
  localparam logic [7:0] SEG_2 = 8'h25;
  localparam logic [7:0] SEG_3 = 8'h0D;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h49;
  localparam logic [7:0] SEG_6 = 8'h41;
  localparam logic [7:0] SEG_7 = 8'h1F;
  localparam logic [7:0] SEG_8 = 8'h01;
  localparam logic [7:0] SEG_9 = 8'h09;
  localparam logic [7:0] SEG_A = 8'h11;
  localparam logic [7:0] SEG_B = 8'h00;
  localparam logic [7:0] SEG_C = 8'h63;
  localparam logic [7:0] SEG_D = 8'h02;
  localparam logic [7:0] SEG_E = 8'h61;
  localparam logic [7:0] SEG_F = 8'h71;

  typedef enum logic [1:0] {
    LO = 2'd0,
    HI = 2'd1,
    WR = 2'd2
  } seg_state_t;

endpackage

// File: rtl/seg_writer_if.sv
// Nibble handshake in, RAM write port and status out; master is the producer/observer, slave is the writer.
// Pure wiring, no latency; seg_ready is the only backpressure signal.
interface seg_writer_if;
  logic [7:0] seg_in;
  logic       seg_valid;
  logic       seg_ready;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] count;
  logic       full;
  logic       err;

  modport master (
    output seg_in, seg_valid,
    input  seg_ready, wr_en, wr_addr, wr_data, count, full, err
  );

  modport slave (
    input  seg_in, seg_valid,
    output seg_ready, wr_en, wr_addr, wr_data, count, full, err
  );
endinterface

// File: rtl/seg_decode.sv
// Seven-segment pattern to hex nibble; valid drops for any of the 240 unlisted patterns.
// Combinational, zero latency, no backpressure.
module seg_decode
  import seg_pkg::*;
(
  input  logic [7:0] seg_in,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b1;
    case (seg_in)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_writer.sv
// Packs pairs of decoded seven-segment nibbles into bytes for an 8x8 RAM; write strobe one cycle after the high nibble.
// seg_ready low in WR and while full; SEG_WRITER_WRAP_EN makes the buffer a ring that never fills.
module seg_writer
  import seg_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  seg_writer_if.slave  bus
);

  localparam logic [3:0] CNT_MAX = 4'(SEG_DEPTH);

  seg_state_t state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] count_q, count_d;
  logic       full_q, full_d;
  logic       err_q, err_d;
  logic [3:0] lo_nib_q, lo_nib_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic [3:0] dec_nib;
  logic       dec_vld;
  logic       rdy;
  logic       xfer;

  seg_decode u_dec (
    .seg_in (bus.seg_in),
    .nibble (dec_nib),
    .valid  (dec_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LO;
      ptr_q     <= 3'd0;
      count_q   <= 4'd0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      lo_nib_q  <= 4'h0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      err_q     <= err_d;
      lo_nib_q  <= lo_nib_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    full_d    = full_q;
    err_d     = err_q;
    lo_nib_d  = lo_nib_q;
    wr_data_d = wr_data_q;
    xfer      = bus.seg_valid && rdy;

    // An undecodable accepted pattern only flags err; the FSM does not move.
    case (state_q)
      LO: begin
        if (xfer) begin
          if (dec_vld) begin
            lo_nib_d = dec_nib;
            state_d  = HI;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HI: begin
        if (xfer) begin
          if (dec_vld) begin
            wr_data_d = {dec_nib, lo_nib_q};
            state_d   = WR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WR: begin
        state_d = LO;
        ptr_d   = ptr_q + 3'd1;
        if (count_q != CNT_MAX) begin
          count_d = count_q + 4'd1;
        end
`ifndef SEG_WRITER_WRAP_EN
        full_d = (count_q + 4'd1 == CNT_MAX);
`endif
      end
      default: state_d = LO;
    endcase

    // start wins over both a same-cycle handshake and the post-write increment.
    if (start) begin
      state_d  = LO;
      ptr_d    = 3'd0;
      count_d  = 4'd0;
      full_d   = 1'b0;
      err_d    = 1'b0;
      lo_nib_d = 4'h0;
    end
  end

  always_comb begin
    rdy           = !rst && !full_q && (state_q == LO || state_q == HI);
    bus.seg_ready = rdy;
    bus.wr_en     = !rst && (state_q == WR);
    bus.wr_addr   = ptr_q;
    bus.wr_data   = wr_data_q;
    bus.count     = count_q;
    bus.full      = full_q;
    bus.err       = err_q;
  end

endmodule

// File: tb/tb_seg_writer.sv
// Directed bench for seg_writer: per-cycle vector table plus hand sequences for fill, wrap/full, and reset mid-byte.
// Works for both builds; SEG_WRITER_WRAP_EN selects the expected behaviour after the 8th byte.
module tb_seg_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  seg_writer_if u_if ();

  seg_writer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       vld;
    logic [7:0] seg;
    logic       rdy;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [3:0] cnt;
    logic       full;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  logic [7:0] enc [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                           8'h01, 8'h09, 8'h11, 8'h00, 8'h63, 8'h02, 8'h61, 8'h71};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic vld, input logic [7:0] seg,
                     input logic rdy, input logic wr, input logic [2:0] addr,
                     input logic [7:0] data, input logic [3:0] cnt, input logic err);
    vec_t v;
    v.st = st; v.vld = vld; v.seg = seg; v.rdy = rdy; v.wr = wr;
    v.addr = addr; v.data = data; v.cnt = cnt; v.full = 1'b0; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic send_nib(input logic [7:0] s);
    int n;
    u_if.seg_in    = s;
    u_if.seg_valid = 1'b1;
    n = 0;
    while (!u_if.seg_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", u_if.seg_ready, 1'b1);
    @(posedge clk);
    #1 u_if.seg_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [2:0] addr, input logic [3:0] cnt);
    send_nib(enc[b[3:0]]);
    send_nib(enc[b[7:4]]);
    @(negedge clk);
    #1;
    chk($sformatf("byte%0h_wr_en", b), u_if.wr_en, 1'b1);
    chk($sformatf("byte%0h_addr", b), u_if.wr_addr, addr);
    chk($sformatf("byte%0h_data", b), u_if.wr_data, b);
    chk($sformatf("byte%0h_cnt", b), u_if.count, cnt);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    u_if.seg_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] fill_a [8];
    fill_a = '{8'h0D, 8'h82, 8'h21, 8'h03, 8'h50, 8'h20, 8'h23, 8'hF0};

    //   st vld seg    rdy wr addr data  cnt err
    add(0, 1, 8'h0D, 1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'h25, 1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 8'h23, 0, 0);
    add(0, 0, 8'h00, 1, 0, 1, 8'h23, 1, 0);
    add(0, 1, 8'hFF, 1, 0, 1, 8'h23, 1, 0);
    add(0, 1, 8'h03, 1, 0, 1, 8'h23, 1, 1);
    add(0, 1, 8'h9F, 1, 0, 1, 8'h23, 1, 1);
    add(0, 0, 8'h00, 0, 1, 1, 8'h10, 1, 1);
    add(0, 1, 8'h49, 1, 0, 2, 8'h10, 2, 1);
    add(0, 1, 8'hAA, 1, 0, 2, 8'h10, 2, 1);
    add(0, 1, 8'h01, 1, 0, 2, 8'h10, 2, 1);
    add(0, 0, 8'h00, 0, 1, 2, 8'h85, 2, 1);
    add(0, 1, 8'h49, 1, 0, 3, 8'h85, 3, 1);
    add(1, 1, 8'h01, 1, 0, 3, 8'h85, 3, 1);
    add(0, 1, 8'h01, 1, 0, 0, 8'h85, 0, 0);
    add(0, 1, 8'h11, 1, 0, 0, 8'h85, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 8'hA8, 0, 0);
    add(0, 1, 8'h03, 1, 0, 1, 8'hA8, 1, 0);
    add(0, 1, 8'h9F, 1, 0, 1, 8'hA8, 1, 0);
    add(1, 0, 8'h00, 0, 1, 1, 8'h10, 1, 0);
    add(0, 1, 8'h0D, 1, 0, 0, 8'h10, 0, 0);
    add(0, 1, 8'h25, 1, 0, 0, 8'h10, 0, 0);
    add(0, 1, 8'h99, 0, 1, 0, 8'h23, 0, 0);
    add(0, 1, 8'h99, 1, 0, 1, 8'h23, 1, 0);
    add(0, 1, 8'h41, 1, 0, 1, 8'h23, 1, 0);
    add(0, 1, 8'h41, 0, 1, 1, 8'h64, 1, 0);
    add(0, 0, 8'h00, 1, 0, 2, 8'h64, 2, 0);

    u_if.seg_in    = 8'h00;
    u_if.seg_valid = 1'b0;

    // Reset: outputs held quiet during rst, then idle state.
    @(negedge clk);
    #1;
    chk("rst_ready", u_if.seg_ready, 1'b0);
    chk("rst_wr_en", u_if.wr_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", u_if.seg_ready, 1'b1);
    chk("post_rst_state", {u_if.wr_en, u_if.wr_addr, u_if.wr_data, u_if.count, u_if.full, u_if.err}, 18'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      start          = vecs[i].st;
      u_if.seg_valid = vecs[i].vld;
      u_if.seg_in    = vecs[i].seg;
      #1;
      chk($sformatf("row%0d_rdy", i),  u_if.seg_ready, vecs[i].rdy);
      chk($sformatf("row%0d_wr", i),   u_if.wr_en,     vecs[i].wr);
      chk($sformatf("row%0d_addr", i), u_if.wr_addr,   vecs[i].addr);
      chk($sformatf("row%0d_data", i), u_if.wr_data,   vecs[i].data);
      chk($sformatf("row%0d_cnt", i),  u_if.count,     vecs[i].cnt);
      chk($sformatf("row%0d_full", i), u_if.full,      vecs[i].full);
      chk($sformatf("row%0d_err", i),  u_if.err,       vecs[i].err);
    end
    @(negedge clk);
    start = 1'b0;
    u_if.seg_valid = 1'b0;

    // Fill all eight addresses in order.
    do_start();
    for (int k = 0; k < 8; k++) begin
      send_byte(fill_a[k], 3'(k), 4'(k));
    end
    @(negedge clk);
    #1;
    chk("fill_cnt", u_if.count, 4'd8);
`ifdef SEG_WRITER_WRAP_EN
    chk("fill_full", u_if.full, 1'b0);
    chk("fill_ready", u_if.seg_ready, 1'b1);
    send_byte(8'h77, 3'd0, 4'd8);
    @(negedge clk);
    #1;
    chk("wrap_cnt", u_if.count, 4'd8);
    chk("wrap_full", u_if.full, 1'b0);
    chk("wrap_addr", u_if.wr_addr, 3'd1);
`else
    chk("fill_full", u_if.full, 1'b1);
    chk("fill_ready", u_if.seg_ready, 1'b0);
    u_if.seg_in    = 8'h03;
    u_if.seg_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("full_hold%0d_rdy", k), u_if.seg_ready, 1'b0);
      chk($sformatf("full_hold%0d_wr", k), u_if.wr_en, 1'b0);
    end
    u_if.seg_valid = 1'b0;
`endif

    // Second fill sweeps every one of the 16 segment codes.
    do_start();
    #1;
    chk("restart_full", u_if.full, 1'b0);
    chk("restart_cnt", u_if.count, 4'd0);
    for (int k = 0; k < 8; k++) begin
      send_byte({4'(2 * k + 1), 4'(2 * k)}, 3'(k), 4'(k));
    end

    // Reset while holding a low nibble: no write follows, everything idle.
    do_start();
    send_nib(8'hFF);
    send_nib(8'h0D);
    @(negedge clk);
    rst            = 1'b1;
    u_if.seg_in    = 8'h25;
    u_if.seg_valid = 1'b1;
    #1;
    chk("rst_hi_ready", u_if.seg_ready, 1'b0);
    chk("rst_hi_wr_en", u_if.wr_en, 1'b0);
    @(negedge clk);
    rst            = 1'b0;
    u_if.seg_valid = 1'b0;
    #1;
    chk("rst_hi_after_wr_en", u_if.wr_en, 1'b0);
    chk("rst_hi_after_ready", u_if.seg_ready, 1'b1);
    chk("rst_hi_after_vals", {u_if.wr_addr, u_if.wr_data, u_if.count, u_if.full, u_if.err}, 17'h0);
    @(negedge clk);
    #1;
    chk("rst_hi_late_wr_en", u_if.wr_en, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
